// File: rtl/vga_capture.sv
// Receive side of the VGA raster link: timing tracking, lock FSM and per-pixel write strobes.
// Optional VGA_CAPTURE_STATS_EN adds measured period outputs and a locked-frame counter.
module vga_capture #(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        de,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err,
  output logic        overflow
`ifdef VGA_CAPTURE_STATS_EN
  ,
  output logic [9:0]  meas_h_total,
  output logic [9:0]  meas_v_total,
  output logic [15:0] frame_count
`endif
);

  localparam logic [9:0]  H_RES_W   = 10'(H_RES);
  localparam logic [9:0]  V_RES_W   = 10'(V_RES);
  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [9:0]  V_TOTAL_W = 10'(V_TOTAL);
  localparam logic [3:0]  LOCK_W    = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state;
  logic        hs1, hs2, vs1, vs2, de1;
  logic [23:0] rgb1;
  logic [9:0]  hcnt, vcnt, x, y;
  logic [3:0]  good;

  logic        h_fall, v_fall, h_bad, v_bad, mismatch, in_range, write;
  logic [9:0]  x_cur, y_cur;
  logic [3:0]  good_next;

  // x_cur/y_cur are the coordinates of the pixel sampled this cycle, after any sync edge in the
  // same cycle has been applied (v edge wins over h edge, so a coincident h edge starts line 0).
  always_comb begin
    h_fall    = hs2 & ~hs1;
    v_fall    = vs2 & ~vs1;
    x_cur     = h_fall ? '0 : x;
    y_cur     = y;
    if (v_fall)
      y_cur = '0;
    else if (h_fall && (x != '0) && (y < V_RES_W))
      y_cur = y + 10'd1;
    in_range  = (x_cur < H_RES_W) && (y_cur < V_RES_W);
    write     = (state == LOCKED) && de1 && in_range;
    h_bad     = h_fall && (({1'b0, hcnt} + 11'd1) != H_TOTAL_W);
    v_bad     = v_fall && (vcnt != V_TOTAL_W);
    mismatch  = (state != SEARCH) && (h_bad || v_bad);
    good_next = good + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= SEARCH;
      hs1         <= 1'b1;
      hs2         <= 1'b1;
      vs1         <= 1'b1;
      vs2         <= 1'b1;
      de1         <= 1'b0;
      rgb1        <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      x           <= '0;
      y           <= '0;
      good        <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
      overflow    <= 1'b0;
`ifdef VGA_CAPTURE_STATS_EN
      meas_h_total <= '0;
      meas_v_total <= '0;
      frame_count  <= '0;
`endif
    end else begin
      hs1  <= h_sync;
      hs2  <= hs1;
      vs1  <= v_sync;
      vs2  <= vs1;
      de1  <= de;
      rgb1 <= {red, green, blue};

      hcnt <= h_fall ? '0 : ((hcnt == '1) ? hcnt : hcnt + 10'd1);
      if (v_fall)
        vcnt <= h_fall ? 10'd1 : 10'd0;
      else if (h_fall && (vcnt != '1))
        vcnt <= vcnt + 10'd1;

      x <= (de1 && (x_cur < H_RES_W)) ? x_cur + 10'd1 : x_cur;
      y <= y_cur;

      pix_valid <= write;
      if (write) begin
        pix_x   <= x_cur;
        pix_y   <= y_cur;
        pix_rgb <= rgb1;
      end
      if (de1 && !in_range)
        overflow <= 1'b1;

      frame_start <= v_fall;
      timing_err  <= mismatch;

      if (mismatch) begin
        state  <= SEARCH;
        good   <= '0;
        locked <= 1'b0;
      end else if (v_fall) begin
        case (state)
          SEARCH: begin
            good <= 4'd1;
            if (LOCK_W <= 4'd1) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              state <= MEASURE;
            end
          end
          MEASURE: begin
            good <= good_next;
            if (good_next >= LOCK_W) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          default: ;
        endcase
      end

`ifdef VGA_CAPTURE_STATS_EN
      if (h_fall)
        meas_h_total <= (hcnt == '1) ? hcnt : hcnt + 10'd1;
      if (v_fall)
        meas_v_total <= vcnt;
      if (v_fall && (state == LOCKED))
        frame_count <= frame_count + 16'd1;
`endif
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a shrunken raster (16x6 totals, 8x4 active).
module tb_vga_capture;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        h_sync = 1'b1, v_sync = 1'b1, de = 1'b0;
  logic [7:0]  red = '0, green = '0, blue = '0;
  logic        pix_valid, frame_start, locked, timing_err, overflow;
  logic [9:0]  pix_x, pix_y;
  logic [23:0] pix_rgb;
`ifdef VGA_CAPTURE_STATS_EN
  logic [9:0]  meas_h_total, meas_v_total;
  logic [15:0] frame_count;
`endif

  always #5 clock = ~clock;

  vga_capture #(
    .H_RES(8), .V_RES(4), .H_TOTAL(16), .V_TOTAL(6), .LOCK_FRAMES(2)
  ) dut (
    .clock(clock), .reset(reset), .h_sync(h_sync), .v_sync(v_sync), .de(de),
    .red(red), .green(green), .blue(blue),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .locked(locked), .timing_err(timing_err), .overflow(overflow)
`ifdef VGA_CAPTURE_STATS_EN
    , .meas_h_total(meas_h_total), .meas_v_total(meas_v_total), .frame_count(frame_count)
`endif
  );

  // One record per raster line: stimulus shape plus what the line must produce.
  typedef struct {
    int vs; int de_n; int hlen;
    int writes; int y; int err; int fs; int lk; int ovf;
  } row_t;

  row_t        rows[42];
  int          checks = 0, failures = 0;
  int          n_pix, n_err, n_fs, line_no = 0;
  logic [9:0]  last_x, last_y;
  logic [23:0] last_rgb;

  always @(negedge clock) begin
    if (pix_valid) begin
      n_pix++;
      last_x   = pix_x;
      last_y   = pix_y;
      last_rgb = pix_rgb;
    end
    if (timing_err)  n_err++;
    if (frame_start) n_fs++;
  end

  function automatic row_t mk(input int vs, de_n, hlen, writes, y, err, fs, lk, ovf);
    row_t r;
    r.vs = vs; r.de_n = de_n; r.hlen = hlen; r.writes = writes; r.y = y;
    r.err = err; r.fs = fs; r.lk = lk; r.ovf = ovf;
    return r;
  endfunction

  task automatic set_frame(input int b, input int lk, input int wr, input int ovf);
    rows[b] = mk(1, 0, 16, 0, 0, 0, 1, lk, ovf);
    for (int k = 1; k <= 4; k++) rows[b+k] = mk(0, 8, 16, wr, k-1, 0, 0, lk, ovf);
    rows[b+5] = mk(0, 0, 16, 0, 0, 0, 0, lk, ovf);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (line %0d): got %0h, expected %0h", name, line_no, act, exp);
    end
  endtask

  task automatic tick(input logic h, input logic v, input logic d, input logic [23:0] c);
    h_sync = h; v_sync = v; de = d; {red, green, blue} = c;
    @(posedge clock);
    #1;
  endtask

  // h_sync low on clocks 0-1, de from clock 2; v_sync low across the whole first line of a frame.
  task automatic run_row(input row_t r);
    n_pix = 0; n_err = 0; n_fs = 0;
    for (int c = 0; c < r.hlen; c++)
      tick((c < 2) ? 1'b0 : 1'b1, (r.vs != 0) ? 1'b0 : 1'b1,
           (c >= 2) && (c < 2 + r.de_n), {8'h12, 8'(line_no), 8'(c - 2)});
    check("writes", n_pix, r.writes);
    if (r.writes > 0) begin
      check("last_x", 32'(last_x), r.writes - 1);
      check("last_y", 32'(last_y), r.y);
      check("last_rgb", 32'(last_rgb), {8'h00, 8'h12, 8'(line_no), 8'(r.writes - 1)});
    end
    check("timing_err", n_err, r.err);
    check("frame_start", n_fs, r.fs);
    check("locked", 32'(locked), r.lk);
    check("overflow", 32'(overflow), r.ovf);
    line_no++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_frame(0, 0, 0, 0);                    // search -> measure
    set_frame(6, 1, 8, 0);                    // locks on second v fall
    set_frame(12, 1, 8, 1);
    rows[12].ovf = 0;
    rows[13] = mk(0, 9, 16, 8, 0, 0, 0, 1, 1); // one de pixel too many
    rows[15].hlen = 17;                       // long line, flagged at next h fall
    rows[16] = mk(0, 8, 16, 0, 0, 1, 0, 0, 1);
    rows[17].lk = 0;
    set_frame(18, 0, 0, 1);
    set_frame(24, 1, 8, 1);                   // relocked
    set_frame(30, 0, 0, 0);                   // after mid-line reset
    set_frame(36, 1, 8, 0);

    repeat (3) tick(1'b1, 1'b1, 1'b0, '0);
    check("reset_pix", 32'({pix_valid, pix_x, pix_y}), 0);
    check("reset_rgb", 32'(pix_rgb), 0);
    check("reset_flags", 32'({frame_start, locked, timing_err, overflow}), 0);
    reset = 1'b0;

    for (int i = 0; i < 30; i++) run_row(rows[i]);

    // Single pixel at (0,0) right after a coincident h/v fall: two-clock latency, then hold.
    run_row(mk(1, 0, 16, 0, 0, 0, 1, 1, 1));
    n_pix = 0; n_err = 0;
    tick(1'b0, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 1'b1, 24'h123456);
    check("lat_early", 32'(pix_valid), 0);
    tick(1'b1, 1'b1, 1'b0, '0);
    check("lat_valid", 32'(pix_valid), 1);
    check("lat_x", 32'(pix_x), 0);
    check("lat_y", 32'(pix_y), 0);
    check("lat_rgb", 32'(pix_rgb), 32'h123456);
    tick(1'b1, 1'b1, 1'b0, '0);
    check("lat_drop", 32'(pix_valid), 0);
    check("lat_hold", 32'(pix_rgb), 32'h123456);
    repeat (11) tick(1'b1, 1'b1, 1'b0, '0);
    check("lat_count", n_pix, 1);
    check("lat_err", n_err, 0);
    line_no++;

    // Reset in the middle of a line while pixels are being written.
    tick(1'b0, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, '0);
    repeat (3) tick(1'b1, 1'b1, 1'b1, 24'hABCDEF);
    check("pre_reset_valid", 32'(pix_valid), 1);
    reset = 1'b1;
    tick(1'b1, 1'b1, 1'b1, 24'hABCDEF);
    check("midreset_pix", 32'({pix_valid, pix_x, pix_y}), 0);
    check("midreset_rgb", 32'(pix_rgb), 0);
    check("midreset_flags", 32'({frame_start, locked, timing_err, overflow}), 0);
    tick(1'b1, 1'b1, 1'b0, '0);
    reset = 1'b0;
    line_no++;

    for (int i = 30; i < 42; i++) run_row(rows[i]);

`ifdef VGA_CAPTURE_STATS_EN
    check("meas_h_total", 32'(meas_h_total), 16);
    check("meas_v_total", 32'(meas_v_total), 6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
